// File: rtl/forwarding_hazard_unit.sv
// Forwarding and load-use hazard unit for a 5-stage RISC-V pipeline.
// A shadow copy of the ID/EX, EX/MEM and MEM/WB control fields is kept
// internally. Operand mux selects are derived from those registered slots.
// The load-use stall is derived from the decode-stage fields against ID/EX.
module forwarding_hazard_unit #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  flush,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  stall,
  output logic [CNT_W-1:0]      stall_count
);

  localparam logic [1:0]            SEL_RF    = 2'b00;
  localparam logic [1:0]            SEL_EXMEM = 2'b01;
  localparam logic [1:0]            SEL_MEMWB = 2'b10;
  localparam logic [REG_ADDR_W-1:0] REG_X0    = {REG_ADDR_W{1'b0}};
  localparam logic [CNT_W-1:0]      CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]      CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

  // ID/EX slot
  logic                  idex_v_q,    idex_v_d;
  logic [REG_ADDR_W-1:0] idex_rs1_q,  idex_rs1_d;
  logic [REG_ADDR_W-1:0] idex_rs2_q,  idex_rs2_d;
  logic                  idex_use1_q, idex_use1_d;
  logic                  idex_use2_q, idex_use2_d;
  logic [REG_ADDR_W-1:0] idex_rd_q,   idex_rd_d;
  logic                  idex_rw_q,   idex_rw_d;
  logic                  idex_mr_q,   idex_mr_d;
  // EX/MEM slot
  logic [REG_ADDR_W-1:0] exmem_rd_q,  exmem_rd_d;
  logic                  exmem_rw_q,  exmem_rw_d;
  // MEM/WB slot
  logic [REG_ADDR_W-1:0] memwb_rd_q,  memwb_rd_d;
  logic                  memwb_rw_q,  memwb_rw_d;
  // Stall performance counter
  logic [CNT_W-1:0]      stall_cnt_q, stall_cnt_d;

  logic                  stall_s;
  logic [1:0]            fwd_a_s;
  logic [1:0]            fwd_b_s;

  // Youngest producer (EX/MEM) wins over MEM/WB; x0 never forwards.
  function automatic logic [1:0] fwd_select(
    input logic                  ex_v,
    input logic                  ex_use,
    input logic [REG_ADDR_W-1:0] ex_rs,
    input logic                  em_rw,
    input logic [REG_ADDR_W-1:0] em_rd,
    input logic                  mw_rw,
    input logic [REG_ADDR_W-1:0] mw_rd
  );
    logic [1:0] sel;
    if (ex_v && ex_use && em_rw && (em_rd != REG_X0) && (em_rd == ex_rs)) begin
      sel = SEL_EXMEM;
    end else if (mw_rw && (mw_rd != REG_X0) && (mw_rd == ex_rs)) begin
      sel = SEL_MEMWB;
    end else begin
      sel = SEL_RF;
    end
    return sel;
  endfunction

  // Load-use detection against the instruction currently in EX; a flush kills it.
  always_comb begin
    stall_s = 1'b0;
    if (id_valid && idex_v_q && idex_mr_q && idex_rw_q && (idex_rd_q != REG_X0) &&
        ((id_use_rs1 && (id_rs1 == idex_rd_q)) ||
         (id_use_rs2 && (id_rs2 == idex_rd_q))) && !flush) begin
      stall_s = 1'b1;
    end else begin
      stall_s = 1'b0;
    end
  end

  // Operand mux selects from the registered slots only.
  always_comb begin
    fwd_a_s = fwd_select(idex_v_q, idex_use1_q, idex_rs1_q,
                         exmem_rw_q, exmem_rd_q, memwb_rw_q, memwb_rd_q);
    fwd_b_s = fwd_select(idex_v_q, idex_use2_q, idex_rs2_q,
                         exmem_rw_q, exmem_rd_q, memwb_rw_q, memwb_rd_q);
  end

  // Shadow-pipeline advance: bubble on flush or stall, otherwise capture ID.
  always_comb begin
    idex_v_d    = idex_v_q;
    idex_rs1_d  = idex_rs1_q;
    idex_rs2_d  = idex_rs2_q;
    idex_use1_d = idex_use1_q;
    idex_use2_d = idex_use2_q;
    idex_rd_d   = idex_rd_q;
    idex_rw_d   = idex_rw_q;
    idex_mr_d   = idex_mr_q;
    exmem_rd_d  = idex_rd_q;
    exmem_rw_d  = idex_rw_q;
    memwb_rd_d  = exmem_rd_q;
    memwb_rw_d  = exmem_rw_q;
    if (flush || stall_s) begin
      // Bubble fields are zeroed so a stale index can never match a producer.
      idex_v_d    = 1'b0;
      idex_rs1_d  = REG_X0;
      idex_rs2_d  = REG_X0;
      idex_use1_d = 1'b0;
      idex_use2_d = 1'b0;
      idex_rd_d   = REG_X0;
      idex_rw_d   = 1'b0;
      idex_mr_d   = 1'b0;
    end else begin
      idex_v_d    = id_valid;
      idex_rs1_d  = id_rs1;
      idex_rs2_d  = id_rs2;
      idex_use1_d = id_use_rs1;
      idex_use2_d = id_use_rs2;
      idex_rd_d   = id_rd;
      idex_rw_d   = id_valid & id_reg_write;
      idex_mr_d   = id_valid & id_mem_read;
    end
  end

  // Saturating stall counter next state.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_s && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_d = stall_cnt_q + CNT_ONE;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Slot and counter registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex_v_q    <= 1'b0;
      idex_rs1_q  <= REG_X0;
      idex_rs2_q  <= REG_X0;
      idex_use1_q <= 1'b0;
      idex_use2_q <= 1'b0;
      idex_rd_q   <= REG_X0;
      idex_rw_q   <= 1'b0;
      idex_mr_q   <= 1'b0;
      exmem_rd_q  <= REG_X0;
      exmem_rw_q  <= 1'b0;
      memwb_rd_q  <= REG_X0;
      memwb_rw_q  <= 1'b0;
      stall_cnt_q <= {CNT_W{1'b0}};
    end else begin
      idex_v_q    <= idex_v_d;
      idex_rs1_q  <= idex_rs1_d;
      idex_rs2_q  <= idex_rs2_d;
      idex_use1_q <= idex_use1_d;
      idex_use2_q <= idex_use2_d;
      idex_rd_q   <= idex_rd_d;
      idex_rw_q   <= idex_rw_d;
      idex_mr_q   <= idex_mr_d;
      exmem_rd_q  <= exmem_rd_d;
      exmem_rw_q  <= exmem_rw_d;
      memwb_rd_q  <= memwb_rd_d;
      memwb_rw_q  <= memwb_rw_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fwd_a_sel   = fwd_a_s;
  assign fwd_b_sel   = fwd_b_s;
  assign stall       = stall_s;
  assign stall_count = stall_cnt_q;

endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Directed bench for forwarding_hazard_unit (4-bit stall counter instance).
module tb_forwarding_hazard_unit;

  logic       clk;
  logic       rst;
  logic       id_valid;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_use_rs1;
  logic       id_use_rs2;
  logic [4:0] id_rd;
  logic       id_reg_write;
  logic       id_mem_read;
  logic       flush;
  logic [1:0] fwd_a_sel;
  logic [1:0] fwd_b_sel;
  logic       stall;
  logic [3:0] stall_count;

  int n_checks;
  int n_errors;

  forwarding_hazard_unit #(
    .REG_ADDR_W(5),
    .CNT_W     (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .id_rd       (id_rd),
    .id_reg_write(id_reg_write),
    .id_mem_read (id_mem_read),
    .flush       (flush),
    .fwd_a_sel   (fwd_a_sel),
    .fwd_b_sel   (fwd_b_sel),
    .stall       (stall),
    .stall_count (stall_count)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic [4:0] rd,
                        input logic rw, input logic mr);
    id_valid     = v;
    id_rs1       = rs1;
    id_rs2       = rs2;
    id_use_rs1   = u1;
    id_use_rs2   = u2;
    id_rd        = rd;
    id_reg_write = rw;
    id_mem_read  = mr;
  endtask

  task automatic nop();
    set_id(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    nop();
    tick();
    tick();
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    flush    = 1'b0;
    nop();
    tick();
    tick();
    check("rst_a", {30'd0, fwd_a_sel}, 32'd0);
    check("rst_b", {30'd0, fwd_b_sel}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_cnt", {28'd0, stall_count}, 32'd0);
    rst = 1'b0;
    drain();

    // EX/MEM forward: addi x5 ; add x6,x5,x5 ; add x10,x1,x2
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0); tick();
    set_id(1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0); tick();
    check("exmem_a", {30'd0, fwd_a_sel}, 32'd1);
    check("exmem_b", {30'd0, fwd_b_sel}, 32'd1);
    set_id(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0); tick();
    check("nodep_a", {30'd0, fwd_a_sel}, 32'd0);
    check("nodep_b", {30'd0, fwd_b_sel}, 32'd0);
    drain();

    // MEM/WB forward: addi x5 ; nop ; add x7,x5,x2
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0); tick();
    nop(); tick();
    set_id(1'b1, 5'd5, 5'd2, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0); tick();
    check("memwb_a", {30'd0, fwd_a_sel}, 32'd2);
    check("memwb_b", {30'd0, fwd_b_sel}, 32'd0);
    drain();

    // Priority: addi x5 ; addi x5 ; add x7,x5,x0
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0); tick();
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0); tick();
    set_id(1'b1, 5'd5, 5'd0, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0); tick();
    check("prio_a", {30'd0, fwd_a_sel}, 32'd1);
    check("prio_b_x0", {30'd0, fwd_b_sel}, 32'd0);
    drain();

    // Load-use: lw x8 ; add x9,x8,x1
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1); tick();
    set_id(1'b1, 5'd8, 5'd1, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0); #2;
    check("lu_stall", {31'd0, stall}, 32'd1);
    check("lu_cnt0", {28'd0, stall_count}, 32'd0);
    tick(); #2;
    check("lu_stall_once", {31'd0, stall}, 32'd0);
    check("lu_cnt1", {28'd0, stall_count}, 32'd1);
    tick();
    check("lu_fwd_a", {30'd0, fwd_a_sel}, 32'd2);
    check("lu_fwd_b", {30'd0, fwd_b_sel}, 32'd0);
    drain();

    // No stall: consumer reads x0, does not use rs1, or is invalid
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1); tick();
    set_id(1'b1, 5'd0, 5'd1, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0); #2;
    check("lu_rs1_x0", {31'd0, stall}, 32'd0);
    tick();
    nop(); tick();
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1); tick();
    set_id(1'b1, 5'd8, 5'd1, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0); #2;
    check("lu_nouse1", {31'd0, stall}, 32'd0);
    set_id(1'b0, 5'd8, 5'd8, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0); #1;
    check("lu_invalid", {31'd0, stall}, 32'd0);
    check("lu_cnt_hold", {28'd0, stall_count}, 32'd1);
    drain();

    // Flush beats stall; killed consumer (rd x9) must not forward later
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1); tick();
    set_id(1'b1, 5'd8, 5'd1, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
    flush = 1'b1; #2;
    check("fl_stall", {31'd0, stall}, 32'd0);
    tick();
    flush = 1'b0;
    check("fl_cnt", {28'd0, stall_count}, 32'd1);
    set_id(1'b1, 5'd9, 5'd9, 1'b1, 1'b1, 5'd10, 1'b1, 1'b0); #2;
    check("fl_bubble_a", {30'd0, fwd_a_sel}, 32'd0);
    check("fl_bubble_stall", {31'd0, stall}, 32'd0);
    tick();
    check("fl_kill_a", {30'd0, fwd_a_sel}, 32'd0);
    check("fl_kill_b", {30'd0, fwd_b_sel}, 32'd0);
    drain();

    // Saturation: 20 load-use pairs on top of the existing count of 1
    for (int i = 0; i < 20; i++) begin
      set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1); tick();
      set_id(1'b1, 5'd8, 5'd1, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0); #2;
      check("sat_stall", {31'd0, stall}, 32'd1);
      tick(); #2;
      check("sat_cnt", {28'd0, stall_count}, (i + 2 > 15) ? 32'd15 : 32'(i + 2));
      tick();
    end
    check("sat_final", {28'd0, stall_count}, 32'hF);
    drain();

    // Asynchronous reset mid-cycle with forwarding and stall active
    set_id(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0); tick();
    set_id(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1); tick();
    check("pre_rst_a", {30'd0, fwd_a_sel}, 32'd1);
    set_id(1'b1, 5'd8, 5'd1, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0); #2;
    check("pre_rst_stall", {31'd0, stall}, 32'd1);
    #1 rst = 1'b1;
    #1;
    check("arst_a", {30'd0, fwd_a_sel}, 32'd0);
    check("arst_b", {30'd0, fwd_b_sel}, 32'd0);
    check("arst_stall", {31'd0, stall}, 32'd0);
    check("arst_cnt", {28'd0, stall_count}, 32'd0);
    tick();
    rst = 1'b0;
    nop();
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/forwarding_hazard_unit.md
Name: forwarding_hazard_unit

Overview:
- Produces the 2-bit `select` codes that drive the EX-stage operand A/B 3-input 32-bit muxes, and the load-use `stall` for the 5-stage RISC-V pipeline.
- Keeps its own shadow pipeline of destination-register and control bits for the ID/EX, EX/MEM and MEM/WB slots, so the core only feeds decode-stage fields.
- Sits beside the hazard/control logic. Outputs go to the operand muxes and the PC / IF-ID enables.

Parameters:
- REG_ADDR_W, 5, register index width
- CNT_W, 32, stall performance counter width

Ports:
- clk  input  1  pipeline clock, rising edge
- rst  input  1  asynchronous, active-high reset
- id_valid  input  1  ID stage holds a real instruction
- id_rs1  input  REG_ADDR_W  source register 1 of the ID instruction
- id_rs2  input  REG_ADDR_W  source register 2 of the ID instruction
- id_use_rs1  input  1  ID instruction reads rs1
- id_use_rs2  input  1  ID instruction reads rs2
- id_rd  input  REG_ADDR_W  destination of the ID instruction
- id_reg_write  input  1  ID instruction writes rd
- id_mem_read  input  1  ID instruction is a load
- flush  input  1  branch/jump taken in EX; kill the ID instruction
- fwd_a_sel  output  2  operand A mux select
- fwd_b_sel  output  2  operand B mux select
- stall  output  1  load-use hazard; hold PC and IF/ID
- stall_count  output  CNT_W  number of cycles with stall=1

Behaviour:
- Select encoding for the operand muxes:
  - 00 = register-file operand (in_0)
  - 01 = EX/MEM ALU result (in_1)
  - 10 = MEM/WB write-back data (in_2)
  - 11 is never driven.
- Shadow slots:
  - IDEX holds {v, rs1, rs2, use1, use2, rd, rw, mr}.
  - EXMEM holds {rd, rw}.
  - MEMWB holds {rd, rw}.
- Every rising edge, in priority order:
  - If rst: all slots cleared (v=0, rw=0, mr=0, indices 0).
  - Else if flush: IDEX <= bubble (v=0, rw=0, mr=0). EXMEM <= IDEX rd/rw. MEMWB <= EXMEM.
  - Else if stall: same as flush. The bubble is inserted and the ID instruction stays in ID.
  - Else: IDEX <= ID inputs (v=id_valid; rw and mr gated by id_valid). EXMEM <= IDEX. MEMWB <= EXMEM.
- flush beats stall in the same cycle. A flushed cycle is not counted as a stall.
- fwd_a_sel is combinational from registered slots only (Moore; 0-cycle latency relative to the EX instruction):
  - 01 if IDEX.v & IDEX.use1 & EXMEM.rw & EXMEM.rd!=0 & EXMEM.rd==IDEX.rs1
  - else 10 if MEMWB.rw & MEMWB.rd!=0 & MEMWB.rd==IDEX.rs1
  - else 00.
- fwd_b_sel: identical rule using rs2/use2.
- EX/MEM has priority over MEM/WB when both match (youngest producer wins).
- Register x0 never forwards and never causes a stall.
- stall (combinational):
  - stall = id_valid & IDEX.v & IDEX.mr & IDEX.rw & IDEX.rd!=0 & ((id_use_rs1 & id_rs1==IDEX.rd) | (id_use_rs2 & id_rs2==IDEX.rd)) & ~flush.
  - Exactly one stall cycle per load-use pair. After the bubble, the load is in EX/MEM and no further stall occurs. The load result reaches the consumer via MEM/WB (sel 10).
- stall_count:
  - Increments on each rising edge where stall=1.
  - Saturates at all-ones (no wrap).
- Reset values, asserted asynchronously:
  - fwd_a_sel=00, fwd_b_sel=00, stall=0, stall_count=0.
  - Reset mid-stall drops stall immediately.
  - No X on any output after reset.
- Invalid ID inputs (id_valid=0) never create a hazard, regardless of the field values.

Test Plan:
- Reset: assert rst asynchronously mid-cycle with slots loaded -> fwd_a_sel=00, fwd_b_sel=00, stall=0, stall_count=0 before the next edge.
- EX/MEM forward: `addi x5` then `add x6,x5,x5` -> in the consumer's EX cycle fwd_a_sel=01, fwd_b_sel=01. One cycle later, with a non-dependent instruction in EX, both are 00.
- MEM/WB forward and priority:
  - `addi x5`, `nop`, `add x7,x5,x2` -> fwd_a_sel=10, fwd_b_sel=00.
  - `addi x5`, `addi x5`, `add x7,x5,x0` -> fwd_a_sel=01 (youngest wins).
- Load-use: `lw x8`, then `add x9,x8,x1` -> stall=1 for exactly 1 cycle, stall_count 0->1. The consumer then sees fwd_a_sel=10.
  - Same sequence with rs1=x0 or id_use_rs1=0 -> stall=0.
- Flush vs stall: the load-use condition and flush=1 in the same cycle -> stall=0, IDEX becomes a bubble, stall_count unchanged. The next cycle has no forwarding from the killed instruction.
- Saturation: with CNT_W=4, force 20 consecutive load-use stalls -> stall_count holds 4'hF.
